// File: rtl/wrr_req_client.sv
// Requester-side client for the weighted round-robin arbiter: per-requester pending
// counters drive req, each valid grant is served for SVC_CYC cycles and closed with ack.
module wrr_req_client #(
   parameter int unsigned N_REQ   = 32,
   parameter int unsigned ID_W    = 5,
   parameter int unsigned CNT_W   = 4,
   parameter int unsigned SVC_CYC = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enq_valid,
   input  logic [ID_W-1:0]  enq_id,
   output logic             enq_ready,
   output logic [N_REQ-1:0] req,
   output logic             ack,
   input  logic [N_REQ-1:0] gnt_w,
   input  logic [ID_W-1:0]  gnt_id,
   output logic             done_valid,
   output logic [ID_W-1:0]  done_id,
   output logic             err_proto
);

   localparam int unsigned      SVC_W   = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [N_REQ-1:0] GNT_ONE = N_REQ'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SERVE = 2'd1,
      ST_ACK   = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [SVC_W-1:0]   svc_q, svc_d;
   logic [ID_W-1:0]    cur_id_q, cur_id_d;
   logic [N_REQ-1:0]   cur_w_q, cur_w_d;
   logic               ack_q, ack_d;
   logic [ID_W-1:0]    done_id_q, done_id_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   pend_q [N_REQ];
   logic [CNT_W-1:0]   pend_d [N_REQ];

   logic               gnt_onehot_c;
   logic               gnt_match_c;
   logic               gnt_valid_c;
   logic               deq_c;
   logic               enq_fire_c;

   // Request vector and back-pressure come straight from the registered counters.
   always_comb begin
      for (int i = 0; i < int'(N_REQ); i++) begin
         req[i] = (pend_q[i] != '0);
      end
   end

   assign enq_ready  = (pend_q[enq_id] != CNT_MAX);
   assign enq_fire_c = enq_valid & enq_ready;

   assign gnt_onehot_c = (gnt_w != '0) && ((gnt_w & (gnt_w - GNT_ONE)) == '0);
   assign gnt_match_c  = (gnt_w == (GNT_ONE << gnt_id));
   assign gnt_valid_c  = gnt_onehot_c & gnt_match_c & req[gnt_id];

   // Grant acceptance, service countdown and ack sequencing.
   always_comb begin
      state_d   = state_q;
      svc_d     = svc_q;
      cur_id_d  = cur_id_q;
      cur_w_d   = cur_w_q;
      ack_d     = 1'b0;
      done_id_d = done_id_q;
      err_d     = err_q;
      deq_c     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (gnt_w != '0) begin
               if (gnt_valid_c) begin
                  cur_id_d = gnt_id;
                  cur_w_d  = gnt_w;
                  svc_d    = SVC_W'(SVC_CYC - 1);
                  if (SVC_CYC == 1) begin
                     state_d   = ST_ACK;
                     ack_d     = 1'b1;
                     done_id_d = gnt_id;
                  end else begin
                     state_d = ST_SERVE;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_SERVE: begin
            if (gnt_w != cur_w_q) begin
               err_d = 1'b1;
            end
            svc_d = svc_q - SVC_W'(1);
            if (svc_q == SVC_W'(1)) begin
               state_d   = ST_ACK;
               ack_d     = 1'b1;
               done_id_d = cur_id_q;
            end
         end
         ST_ACK: begin
            deq_c   = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Enqueue and completion on the same id cancel out.
   always_comb begin
      for (int i = 0; i < int'(N_REQ); i++) begin
         logic inc;
         logic dec;
         inc       = enq_fire_c && (enq_id == ID_W'(i));
         dec       = deq_c && (cur_id_q == ID_W'(i));
         pend_d[i] = pend_q[i];
         if (inc && !dec) begin
            pend_d[i] = pend_q[i] + CNT_W'(1);
         end else if (dec && !inc) begin
            pend_d[i] = pend_q[i] - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         svc_q     <= '0;
         cur_id_q  <= '0;
         cur_w_q   <= '0;
         ack_q     <= 1'b0;
         done_id_q <= '0;
         err_q     <= 1'b0;
         for (int i = 0; i < int'(N_REQ); i++) begin
            pend_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         svc_q     <= svc_d;
         cur_id_q  <= cur_id_d;
         cur_w_q   <= cur_w_d;
         ack_q     <= ack_d;
         done_id_q <= done_id_d;
         err_q     <= err_d;
         for (int i = 0; i < int'(N_REQ); i++) begin
            pend_q[i] <= pend_d[i];
         end
      end
   end

   assign ack        = ack_q;
   assign done_valid = ack_q;
   assign done_id    = done_id_q;
   assign err_proto  = err_q;

endmodule

// File: doc/wrr_req_client.md
# wrr_req_client

Requester-side counterpart of the weighted round-robin arbitration interface. It holds per-requester pending-work counters, drives the 32-bit `req` vector toward the arbiter and consumes each grant. Each grant is held for a programmable service time, then completed with a one-cycle `ack`. It serves as the reusable initiator model and as the RTL front end for clients sitting on the WRR arbiter.

## Interface
Parameters:
- `N_REQ`, default 32: number of requesters; fixed to 32 by the `req`/`gnt_w` width.
- `ID_W`, default 5: width of requester index (log2 `N_REQ`).
- `CNT_W`, default 4: pending counter width; max pending per requester is 2^`CNT_W`-1.
- `SVC_CYC`, default 2: cycles from grant acceptance to `ack`; legal range 1..255.

Ports:
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `enq_valid` input 1: add one unit of pending work for `enq_id`.
- `enq_id` input `ID_W`: requester receiving the work.
- `enq_ready` output 1: enqueue accepted when `enq_valid & enq_ready`.
- `req` output 32: bit i = requester i has pending work.
- `ack` output 1: one-cycle completion of the current grant.
- `gnt_w` input 32: one-hot grant vector from the arbiter; all-zero means no grant.
- `gnt_id` input `ID_W`: encoded index of the granted requester.
- `done_valid` output 1: pulses together with `ack`.
- `done_id` output `ID_W`: requester completed; valid with `done_valid`.
- `err_proto` output 1: sticky protocol-violation flag.

## Operation
- Counters `pend[0..31]` are `CNT_W` bits. `req[i] = (pend[i] != 0)`, decoded from registered counters.
- `enq_ready = (pend[enq_id] != max)`. It depends only on the current count, so a simultaneous dequeue does not make a full counter ready.
- FSM states: IDLE, SERVE, ACK.
  - **IDLE → SERVE:** a grant is valid when `gnt_w` is one-hot, `gnt_w == 1<<gnt_id`, and `req[gnt_id]=1`. Latch `gnt_id` into `cur_id` and `gnt_w` into `cur_w`. Load the service counter with `SVC_CYC-1`. If `SVC_CYC==1`, go directly to ACK.
  - **SERVE:** decrement the service counter; go to ACK when it reaches 0.
  - **ACK:** `ack=1`, `done_valid=1`, `done_id=cur_id`. `pend[cur_id]` decrements at the clock edge closing this cycle. The next state is IDLE.
- Grant invalid in IDLE (non-zero but not one-hot, id mismatch, or granted requester not requesting): set `err_proto`, ignore the grant, stay in IDLE.
- `gnt_w != cur_w` during SERVE: set `err_proto`; service continues with the latched `cur_id`. During ACK, `gnt_w` is ignored.
- Enqueue and ack on the same id in the same cycle: net count unchanged.
- Enqueue and ack on different ids: both counters update independently.
- `err_proto` clears only on reset.

## Timing
- Reset values: `req=0`, `ack=0`, `done_valid=0`, `done_id=0`, `err_proto=0`, all `pend=0`, FSM in IDLE. `enq_ready=1` after reset.
- Reset asserted mid-operation clears everything immediately. No pending `ack` is issued after reset release.
- Enqueue at edge T: `req` bit visible in cycle T+1.
- Grant sampled at edge T in IDLE: `ack` is high during cycle T+`SVC_CYC` for exactly one cycle.
- Arbiter contract:
  - The arbiter holds `gnt_w`/`gnt_id` stable until it samples `ack`.
  - It may present a new grant in the cycle after `ack`. The client samples that grant in IDLE with no idle gap, giving a back-to-back throughput of one grant per `SVC_CYC+1` cycles.
- After the final unit of requester i completes, `req[i]` drops in the cycle following `ack`.

## Test plan
- Reset: assert `rst=0` mid-run → `req=0`, `ack=0`, `err_proto=0`, `enq_ready=1`. After release, no spurious `ack`.
- Basic flow: enqueue id 3 twice → `req=0x0000_0008`. Grant `gnt_w=0x8`, `gnt_id=3` at T (`SVC_CYC=2`) → `ack` and `done_id=3` at T+2, `req` still `0x8`. Second grant → `ack`, then `req=0`.
- Full counter (`CNT_W=4`): enqueue id 7 fifteen times → `enq_ready=0` on the 16th attempt, `pend[7]=15`. One ack → `enq_ready=1`.
- Simultaneous enq/ack: `pend[5]=1`, enqueue id 5 in the `ack` cycle → `pend[5]` stays 1, `req[5]` stays 1.
- Protocol errors:
  - `gnt_w=0x3` → `err_proto=1`, no `ack`.
  - After reset, grant id 9 with `req[9]=0` → `err_proto=1`.
  - `gnt_w` changed during SERVE → `err_proto=1`, `ack` still issued for the latched id.
- Back-to-back: ids 0 and 31 pending, arbiter grants id 0 then id 31 on the cycle after `ack` → two acks spaced `SVC_CYC+1` cycles apart, `done_id` 0 then 31.
